// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder built around one 4-bit carry-lookahead slice, LSB nibble first.
// Define NIBBLE_SERIAL_OVF_EN to add the registered signed-overflow output Ovf.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
`ifdef NIBBLE_SERIAL_OVF_EN
    output logic             Cout,
    output logic             Ovf
`else
    output logic             Cout
`endif
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  a_sh, b_sh, res_sh, res_next;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic [5:0]        nib;
    logic              load, last;

    // Returns {carry into bit 3, carry out of bit 3, 4-bit sum}.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] g, p;
        logic       c1, c2, c3, c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c3, c4, p ^ {c3, c2, c1, ci}};
    endfunction

    assign nib  = cla4(a_sh[3:0], b_sh[3:0], carry);
    assign load = start && (state != RUN);
    assign last = (state == RUN) && (cnt == LAST);

    generate
        if (WIDTH == 4) begin : g_one_nibble
            assign res_next = nib[3:0];
        end else begin : g_multi_nibble
            assign res_next = {nib[3:0], res_sh[WIDTH-1:4]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand shifters, slice carry, counter and the result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            S      <= '0;
            Cout   <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
            Ovf    <= 1'b0;
`endif
        end else if (load) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 4;
            b_sh   <= b_sh >> 4;
            res_sh <= res_next;
            carry  <= nib[4];
            cnt    <= cnt + CW'(1);
            if (last) begin
                S    <= res_next;
                Cout <= nib[4];
`ifdef NIBBLE_SERIAL_OVF_EN
                Ovf  <= nib[5] ^ nib[4];
`endif
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: directed and random adds on WIDTH=16 and WIDTH=4 instances vs. plain arithmetic.
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, cin, start4, cin4;
    logic [15:0] a, b;
    logic [3:0]  a4, b4;
    wire         busy, done, cout, busy4, done4, cout4;
    wire  [15:0] s;
    wire  [3:0]  s4;
`ifdef NIBBLE_SERIAL_OVF_EN
    wire         ovf, ovf4;
`endif

    nibble_serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Cin(cin),
        .busy(busy), .done(done), .S(s),
`ifdef NIBBLE_SERIAL_OVF_EN
        .Cout(cout), .Ovf(ovf)
`else
        .Cout(cout)
`endif
    );

    nibble_serial_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .Cin(cin4),
        .busy(busy4), .done(done4), .S(s4),
`ifdef NIBBLE_SERIAL_OVF_EN
        .Cout(cout4), .Ovf(ovf4)
`else
        .Cout(cout4)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] prev_s;
    logic        prev_c;
    logic [3:0]  prev_s4;
    logic        prev_c4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start in the current cycle (IDLE or DONE); returns in the DONE cycle.
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input bit junk);
        logic [16:0] full;
        logic        exp_ovf;
        full    = {1'b0, ta} + {1'b0, tb_} + 17'(tc);
        exp_ovf = (ta[15] == tb_[15]) && (full[15] != ta[15]);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            if (junk) begin
                start = 1'b1; a = 16'hAAAA; b = 16'($urandom); cin = 1'b1;
            end else begin
                start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("s_hold", 32'(s), 32'(prev_s));
            chk("cout_hold", 32'(cout), 32'(prev_c));
            tick();
        end
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("sum", 32'(s), 32'(full[15:0]));
        chk("cout", 32'(cout), 32'(full[16]));
`ifdef NIBBLE_SERIAL_OVF_EN
        chk("ovf", 32'(ovf), 32'(exp_ovf));
`endif
        prev_s = full[15:0];
        prev_c = full[16];
    endtask

    task automatic idle16();
        start = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_s", 32'(s), 32'(prev_s));
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
        logic [4:0] full;
        logic       exp_ovf;
        full    = {1'b0, ta} + {1'b0, tb_} + 5'(tc);
        exp_ovf = (ta[3] == tb_[3]) && (full[3] != ta[3]);
        a4 = ta; b4 = tb_; cin4 = tc; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("w4_busy", 32'(busy4), 32'd1);
        chk("w4_done_run", 32'(done4), 32'd0);
        chk("w4_s_hold", 32'(s4), 32'(prev_s4));
        tick();
        chk("w4_done", 32'(done4), 32'd1);
        chk("w4_sum", 32'(s4), 32'(full[3:0]));
        chk("w4_cout", 32'(cout4), 32'(full[4]));
`ifdef NIBBLE_SERIAL_OVF_EN
        chk("w4_ovf", 32'(ovf4), 32'(exp_ovf));
`endif
        prev_s4 = full[3:0];
        prev_c4 = full[4];
        tick();
        chk("w4_idle", 32'(done4), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cin = 1'b0; a = '0; b = '0;
        start4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        prev_s = '0; prev_c = 1'b0; prev_s4 = '0; prev_c4 = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_s4", 32'(s4), 32'd0);
`ifdef NIBBLE_SERIAL_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle16();

        run16(16'h1234, 16'h4321, 1'b0, 1'b0);
        idle16();
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle16();
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        idle16();
        run16(16'h0F0F, 16'h00F1, 1'b1, 1'b1);
        run16(16'h0001, 16'h0002, 1'b0, 1'b0);
        idle16();

        // Abort an add with reset in the middle of the second RUN cycle.
        a = 16'($urandom); b = 16'($urandom); cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #4;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_s", 32'(s), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        prev_s = '0; prev_c = 1'b0; prev_s4 = '0; prev_c4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", 32'(done), 32'd0);
        run16(16'h0005, 16'h0006, 1'b0, 1'b0);
        idle16();

        for (int i = 0; i < 20; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) idle16();
        end
        idle16();

        run4(4'h9, 4'h8, 1'b1);
        for (int i = 0; i < 12; i++) run4(4'($urandom), 4'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
